t48_timer_ctrl: RTL and testbench

//  Sequences the T48 timer/counter datapath. Decodes timer opcodes from the instruction

---
 rtl/t48_timer_ctrl.sv | 174 +++++++++++++++++
 tb/tb_t48_timer_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/t48_timer_ctrl.sv
// T48 timer/counter sequencer: decodes timer opcodes into state-aligned strobes and
// owns the timer flag, the timer interrupt enable and the pending interrupt request.
`timescale 1ns/1ps
module t48_timer_ctrl #(
  parameter logic [2:0] EXEC_STATE = 3'b011,
  parameter logic [2:0] RD_STATE   = 3'b001
) (
  input  logic       clk_i,
  input  logic       res_i,
  input  logic       en_clk_i,
  input  logic [2:0] clk_mstate_i,
  input  logic [7:0] opc_i,
  input  logic       opc_valid_i,
  input  logic       overflow_i,
  input  logic       int_ack_i,
  output logic       start_t_o,
  output logic       start_cnt_o,
  output logic       stop_tcnt_o,
  output logic       write_timer_o,
  output logic       read_timer_o,
  output logic       tf_o,
  output logic       jtf_take_o,
  output logic       jtf_strobe_o,
  output logic       tim_int_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_PEND, ST_JTF2} state_t;
  typedef enum logic [2:0] {
    OP_STRT_T, OP_STRT_CNT, OP_STOP, OP_MOV_TA, OP_MOV_AT, OP_EN_I, OP_DIS_I, OP_JTF
  } op_t;

  state_t state_q, state_d;
  op_t    op_q, op_d, dec_op;
  logic   dec_hit;
  logic   jump_q, jump_d;
  logic   tf_q, tf_d;
  logic   ten_q, ten_d;
  logic   pend_q, pend_d;
  logic   start_t_q, start_t_d;
  logic   start_cnt_q, start_cnt_d;
  logic   stop_q, stop_d;
  logic   write_q, write_d;
  logic   read_q, read_d;
  logic   jtf_strobe_q, jtf_strobe_d;
  logic   jtf_take_q, jtf_take_d;
  logic   tf_clr, pend_clr;

  always_comb begin
    dec_hit = 1'b1;
    dec_op  = OP_STRT_T;
    case (opc_i)
      8'h55:   dec_op = OP_STRT_T;
      8'h45:   dec_op = OP_STRT_CNT;
      8'h65:   dec_op = OP_STOP;
      8'h62:   dec_op = OP_MOV_TA;
      8'h42:   dec_op = OP_MOV_AT;
      8'h25:   dec_op = OP_EN_I;
      8'h35:   dec_op = OP_DIS_I;
      8'h16:   dec_op = OP_JTF;
      default: dec_hit = 1'b0;
    endcase
  end

  // NOTE: every *_d gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    jump_d       = jump_q;
    ten_d        = ten_q;
    start_t_d    = 1'b0;
    start_cnt_d  = 1'b0;
    stop_d       = 1'b0;
    write_d      = 1'b0;
    read_d       = 1'b0;
    jtf_strobe_d = 1'b0;
    jtf_take_d   = 1'b0;
    tf_clr       = 1'b0;
    pend_clr     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (opc_valid_i && dec_hit) begin
          state_d = ST_PEND;
          op_d    = dec_op;
          if (dec_op == OP_JTF) jump_d = tf_q;
        end
      end
      ST_PEND: begin
        if (op_q == OP_MOV_AT) begin
          // Read window spans RD_STATE..4; it drops on the edge after state 4.
          if (clk_mstate_i == RD_STATE || read_q) read_d = 1'b1;
          if (read_q && clk_mstate_i == 3'b100) state_d = ST_IDLE;
        end else if (clk_mstate_i == EXEC_STATE) begin
          state_d = ST_IDLE;
          case (op_q)
            OP_STRT_T:   start_t_d   = 1'b1;
            OP_STRT_CNT: start_cnt_d = 1'b1;
            OP_STOP:     stop_d      = 1'b1;
            OP_MOV_TA:   write_d     = 1'b1;
            OP_EN_I:     ten_d       = 1'b1;
            OP_DIS_I: begin
              ten_d    = 1'b0;
              pend_clr = 1'b1;
            end
            OP_JTF:      state_d     = ST_JTF2;
            default:     state_d     = ST_IDLE;
          endcase
        end
      end
      ST_JTF2: begin
        if (clk_mstate_i == EXEC_STATE) begin
          jtf_strobe_d = 1'b1;
          jtf_take_d   = jump_q;
          tf_clr       = 1'b1;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Set terms are applied last so they win over clears on the same edge.
    tf_d = tf_q;
    if (tf_clr)     tf_d = 1'b0;
    if (overflow_i) tf_d = 1'b1;

    pend_d = pend_q;
    if (int_ack_i || pend_clr) pend_d = 1'b0;
    if (overflow_i && ten_q)   pend_d = 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk_i or posedge res_i) begin
    if (res_i) begin
      state_q      <= ST_IDLE;
      op_q         <= OP_STRT_T;
      jump_q       <= 1'b0;
      tf_q         <= 1'b0;
      ten_q        <= 1'b0;
      pend_q       <= 1'b0;
      start_t_q    <= 1'b0;
      start_cnt_q  <= 1'b0;
      stop_q       <= 1'b0;
      write_q      <= 1'b0;
      read_q       <= 1'b0;
      jtf_strobe_q <= 1'b0;
      jtf_take_q   <= 1'b0;
    end else if (en_clk_i) begin
      state_q      <= state_d;
      op_q         <= op_d;
      jump_q       <= jump_d;
      tf_q         <= tf_d;
      ten_q        <= ten_d;
      pend_q       <= pend_d;
      start_t_q    <= start_t_d;
      start_cnt_q  <= start_cnt_d;
      stop_q       <= stop_d;
      write_q      <= write_d;
      read_q       <= read_d;
      jtf_strobe_q <= jtf_strobe_d;
      jtf_take_q   <= jtf_take_d;
    end
  end

  assign start_t_o     = start_t_q;
  assign start_cnt_o   = start_cnt_q;
  assign stop_tcnt_o   = stop_q;
  assign write_timer_o = write_q;
  assign read_timer_o  = read_q;
  assign tf_o          = tf_q;
  assign jtf_take_o    = jtf_take_q;
  assign jtf_strobe_o  = jtf_strobe_q;
  assign tim_int_o     = pend_q;

endmodule

// File: tb/tb_t48_timer_ctrl.sv
// Directed vector bench for t48_timer_ctrl: per-cycle stimulus table with hand-computed
// outputs, plus a reset-during-PEND sequence.
`timescale 1ns/1ps
module tb_t48_timer_ctrl;

  logic       clk_i = 1'b0;
  logic       res_i;
  logic       en_clk_i;
  logic [2:0] clk_mstate_i;
  logic [7:0] opc_i;
  logic       opc_valid_i;
  logic       overflow_i;
  logic       int_ack_i;
  logic       start_t_o, start_cnt_o, stop_tcnt_o, write_timer_o, read_timer_o;
  logic       tf_o, jtf_take_o, jtf_strobe_o, tim_int_o;

  t48_timer_ctrl dut (
    .clk_i         (clk_i),
    .res_i         (res_i),
    .en_clk_i      (en_clk_i),
    .clk_mstate_i  (clk_mstate_i),
    .opc_i         (opc_i),
    .opc_valid_i   (opc_valid_i),
    .overflow_i    (overflow_i),
    .int_ack_i     (int_ack_i),
    .start_t_o     (start_t_o),
    .start_cnt_o   (start_cnt_o),
    .stop_tcnt_o   (stop_tcnt_o),
    .write_timer_o (write_timer_o),
    .read_timer_o  (read_timer_o),
    .tf_o          (tf_o),
    .jtf_take_o    (jtf_take_o),
    .jtf_strobe_o  (jtf_strobe_o),
    .tim_int_o     (tim_int_o)
  );

  always #5 clk_i = ~clk_i;

  // Output bundle: {start_t, start_cnt, stop, write, read, tf, take, strobe, int}
  localparam logic [8:0] E_ST  = 9'h100;
  localparam logic [8:0] E_SC  = 9'h080;
  localparam logic [8:0] E_SP  = 9'h040;
  localparam logic [8:0] E_WR  = 9'h020;
  localparam logic [8:0] E_RD  = 9'h010;
  localparam logic [8:0] E_TF  = 9'h008;
  localparam logic [8:0] E_TK  = 9'h004;
  localparam logic [8:0] E_JS  = 9'h002;
  localparam logic [8:0] E_INT = 9'h001;

  logic [8:0] outs;
  assign outs = {start_t_o, start_cnt_o, stop_tcnt_o, write_timer_o, read_timer_o,
                 tf_o, jtf_take_o, jtf_strobe_o, tim_int_o};

  typedef struct {
    logic       en;
    logic [2:0] ms;
    logic [7:0] opc;
    logic       val;
    logic       ovf;
    logic       ack;
    logic [8:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %09b expected %09b", name, act, exp);
    end
  endtask

  task automatic v(input logic en, input logic [2:0] ms, input logic [7:0] opc,
                   input logic val, input logic ovf, input logic ack, input logic [8:0] exp);
    vec_t r;
    r.en = en; r.ms = ms; r.opc = opc; r.val = val; r.ovf = ovf; r.ack = ack; r.exp = exp;
    vecs.push_back(r);
  endtask

  task automatic drive(input logic en, input logic [2:0] ms, input logic [7:0] opc,
                       input logic val, input logic ovf, input logic ack);
    en_clk_i = en; clk_mstate_i = ms; opc_i = opc;
    opc_valid_i = val; overflow_i = ovf; int_ack_i = ack;
  endtask

  initial begin
    res_i = 1'b1;
    drive(1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0);

    // STRT T, with a second opcode during PEND ignored and an en_clk_i=0 hold cycle
    v(1, 0, 8'h55, 1, 0, 0, 9'h0);
    v(1, 1, 8'h65, 1, 0, 0, 9'h0);
    v(1, 2, 8'h00, 0, 0, 0, 9'h0);
    v(1, 3, 8'h00, 0, 0, 0, E_ST);
    v(0, 4, 8'h00, 0, 1, 0, E_ST);
    v(1, 4, 8'h00, 0, 0, 0, 9'h0);
    // non-timer opcode: nothing happens
    v(1, 0, 8'h00, 1, 0, 0, 9'h0);
    v(1, 1, 8'h00, 0, 0, 0, 9'h0);
    v(1, 2, 8'h00, 0, 0, 0, 9'h0);
    v(1, 3, 8'h00, 0, 0, 0, 9'h0);
    v(1, 4, 8'h00, 0, 0, 0, 9'h0);
    // STRT CNT
    v(1, 0, 8'h45, 1, 0, 0, 9'h0);
    v(1, 1, 8'h00, 0, 0, 0, 9'h0);
    v(1, 2, 8'h00, 0, 0, 0, 9'h0);
    v(1, 3, 8'h00, 0, 0, 0, E_SC);
    v(1, 4, 8'h00, 0, 0, 0, 9'h0);
    // EN TCNTI, overflow, ack
    v(1, 0, 8'h25, 1, 0, 0, 9'h0);
    v(1, 1, 8'h00, 0, 0, 0, 9'h0);
    v(1, 2, 8'h00, 0, 0, 0, 9'h0);
    v(1, 3, 8'h00, 0, 0, 0, 9'h0);
    v(1, 4, 8'h00, 0, 1, 0, E_TF | E_INT);
    v(1, 0, 8'h00, 0, 0, 1, E_TF);
    // JTF with TF=1: taken, TF cleared
    v(1, 1, 8'h16, 1, 0, 0, E_TF);
    v(1, 2, 8'h00, 0, 0, 0, E_TF);
    v(1, 3, 8'h00, 0, 0, 0, E_TF);
    v(1, 4, 8'h00, 0, 0, 0, E_TF);
    v(1, 0, 8'h00, 0, 0, 0, E_TF);
    v(1, 1, 8'h00, 0, 0, 0, E_TF);
    v(1, 2, 8'h00, 0, 0, 0, E_TF);
    v(1, 3, 8'h00, 0, 0, 0, E_JS | E_TK);
    v(1, 4, 8'h00, 0, 0, 0, 9'h0);
    // JTF with TF=0: strobe, not taken
    v(1, 0, 8'h16, 1, 0, 0, 9'h0);
    v(1, 1, 8'h00, 0, 0, 0, 9'h0);
    v(1, 2, 8'h00, 0, 0, 0, 9'h0);
    v(1, 3, 8'h00, 0, 0, 0, 9'h0);
    v(1, 4, 8'h00, 0, 0, 0, 9'h0);
    v(1, 0, 8'h00, 0, 0, 0, 9'h0);
    v(1, 1, 8'h00, 0, 0, 0, 9'h0);
    v(1, 2, 8'h00, 0, 0, 0, 9'h0);
    v(1, 3, 8'h00, 0, 0, 0, E_JS);
    v(1, 4, 8'h00, 0, 0, 0, 9'h0);
    // JTF clear coinciding with overflow: TF stays 1, pending set again
    v(1, 0, 8'h00, 0, 1, 0, E_TF | E_INT);
    v(1, 1, 8'h16, 1, 0, 0, E_TF | E_INT);
    v(1, 2, 8'h00, 0, 0, 0, E_TF | E_INT);
    v(1, 3, 8'h00, 0, 0, 0, E_TF | E_INT);
    v(1, 4, 8'h00, 0, 0, 1, E_TF);
    v(1, 0, 8'h00, 0, 0, 0, E_TF);
    v(1, 1, 8'h00, 0, 0, 0, E_TF);
    v(1, 2, 8'h00, 0, 0, 0, E_TF);
    v(1, 3, 8'h00, 0, 1, 0, E_JS | E_TK | E_TF | E_INT);
    v(1, 4, 8'h00, 0, 0, 1, E_TF);
    // DIS TCNTI with overflow on the same edge: set wins; then overflow no longer pends
    v(1, 0, 8'h35, 1, 0, 0, E_TF);
    v(1, 1, 8'h00, 0, 0, 0, E_TF);
    v(1, 2, 8'h00, 0, 0, 0, E_TF);
    v(1, 3, 8'h00, 0, 1, 0, E_TF | E_INT);
    v(1, 4, 8'h00, 0, 0, 1, E_TF);
    v(1, 0, 8'h00, 0, 1, 0, E_TF);
    // EN TCNTI does not raise pending retroactively
    v(1, 1, 8'h25, 1, 0, 0, E_TF);
    v(1, 2, 8'h00, 0, 0, 0, E_TF);
    v(1, 3, 8'h00, 0, 0, 0, E_TF);
    v(1, 4, 8'h00, 0, 0, 0, E_TF);
    // MOV A,T: read window for mstates 1..4
    v(1, 0, 8'h42, 1, 0, 0, E_TF);
    v(1, 1, 8'h00, 0, 0, 0, E_TF | E_RD);
    v(1, 2, 8'h00, 0, 0, 0, E_TF | E_RD);
    v(1, 3, 8'h00, 0, 0, 0, E_TF | E_RD);
    v(1, 4, 8'h00, 0, 0, 0, E_TF | E_RD);
    v(1, 0, 8'h00, 0, 0, 0, E_TF);
    // MOV T,A
    v(1, 0, 8'h62, 1, 0, 0, E_TF);
    v(1, 1, 8'h00, 0, 0, 0, E_TF);
    v(1, 2, 8'h00, 0, 0, 0, E_TF);
    v(1, 3, 8'h00, 0, 0, 0, E_TF | E_WR);
    v(1, 4, 8'h00, 0, 0, 0, E_TF);
    // overflow and ack on the same edge: set wins
    v(1, 0, 8'h00, 0, 1, 1, E_TF | E_INT);
    v(1, 1, 8'h00, 0, 0, 1, E_TF);

    repeat (2) @(posedge clk_i);
    #1 check("reset_state", outs, 9'h0);
    @(negedge clk_i);
    res_i = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk_i);
      drive(vecs[i].en, vecs[i].ms, vecs[i].opc, vecs[i].val, vecs[i].ovf, vecs[i].ack);
      @(posedge clk_i);
      #1 check($sformatf("vec%0d", i), outs, vecs[i].exp);
    end

    // Reset in PEND of STOP TCNT: strobe dropped, TF and everything else back to 0
    @(negedge clk_i);
    drive(1'b1, 3'd0, 8'h65, 1'b1, 1'b0, 1'b0);
    @(posedge clk_i);
    #1 check("stop_pend", outs, E_TF);
    @(negedge clk_i);
    drive(1'b1, 3'd1, 8'h00, 1'b0, 1'b0, 1'b0);
    res_i = 1'b1;
    #1 check("async_reset", outs, 9'h0);
    @(negedge clk_i);
    res_i = 1'b0;
    for (int ms = 2; ms <= 5; ms++) begin
      drive(1'b1, 3'(ms % 5), 8'h00, 1'b0, 1'b0, 1'b0);
      @(posedge clk_i);
      #1 check($sformatf("post_reset_ms%0d", ms % 5), outs, 9'h0);
      @(negedge clk_i);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
